// File: rtl/adpll_gain_scheduler.sv
// Gear-shift and lock controller for one NetworkRing ADPLL node (acquire/shift/track gain scheduling).
// Optional macro ADPLL_GAIN_RAMP_EN: ramp gains one LSB per sample from acq to trk during SHIFT.
module adpll_gain_scheduler #(
  parameter int PDET_WIDTH   = 5,
  parameter int KP_WIDTH     = 5,
  parameter int KI_WIDTH     = 7,
  parameter int LOCK_THRESH  = 2,
  parameter int LOCK_COUNT   = 1024,
  parameter int SHIFT_HOLD   = 16,
  parameter int UNLOCK_COUNT = 8
) (
  input  logic                  fpga_clk_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  sample_i,
  input  logic [PDET_WIDTH-1:0] error_i,
  input  logic [KP_WIDTH-1:0]   kp_acq_i,
  input  logic [KI_WIDTH-1:0]   ki_acq_i,
  input  logic [KP_WIDTH-1:0]   kp_trk_i,
  input  logic [KI_WIDTH-1:0]   ki_trk_i,
  output logic [KP_WIDTH-1:0]   kp_o,
  output logic [KI_WIDTH-1:0]   ki_o,
  output logic                  loop_en_o,
  output logic                  lock_o,
  output logic                  lost_lock_o,
  output logic [1:0]            state_o
);

  localparam int HIT_W  = $clog2(LOCK_COUNT + 1);
  localparam int HOLD_W = $clog2(SHIFT_HOLD + 1);
  localparam int MISS_W = $clog2(UNLOCK_COUNT + 1);

  localparam logic [PDET_WIDTH-1:0] THRESH_V = PDET_WIDTH'(LOCK_THRESH);
  localparam logic [HIT_W-1:0]      LOCK_V   = HIT_W'(LOCK_COUNT);
  localparam logic [HOLD_W-1:0]     HOLD_V   = HOLD_W'(SHIFT_HOLD);
  localparam logic [MISS_W-1:0]     UNLOCK_V = MISS_W'(UNLOCK_COUNT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ACQ   = 2'b01,
    S_SHIFT = 2'b10,
    S_TRACK = 2'b11
  } state_t;

  // Magnitude with the most negative code saturated to the largest positive code.
  function automatic logic [PDET_WIDTH-1:0] sat_abs(input logic signed [PDET_WIDTH-1:0] e);
    logic signed [PDET_WIDTH-1:0] neg;
    neg = -e;
    if (e == {1'b1, {(PDET_WIDTH-1){1'b0}}})
      sat_abs = {1'b0, {(PDET_WIDTH-1){1'b1}}};
    else if (e[PDET_WIDTH-1])
      sat_abs = $unsigned(neg);
    else
      sat_abs = $unsigned(e);
  endfunction

`ifdef ADPLL_GAIN_RAMP_EN
  function automatic logic [KP_WIDTH-1:0] step_kp(input logic [KP_WIDTH-1:0] cur,
                                                  input logic [KP_WIDTH-1:0] tgt);
    if (cur < tgt)      step_kp = cur + 1'b1;
    else if (cur > tgt) step_kp = cur - 1'b1;
    else                step_kp = cur;
  endfunction

  function automatic logic [KI_WIDTH-1:0] step_ki(input logic [KI_WIDTH-1:0] cur,
                                                  input logic [KI_WIDTH-1:0] tgt);
    if (cur < tgt)      step_ki = cur + 1'b1;
    else if (cur > tgt) step_ki = cur - 1'b1;
    else                step_ki = cur;
  endfunction
`endif

  // Stage p0: qualify the incoming sample
  logic signed [PDET_WIDTH-1:0] err_p0;
  logic [PDET_WIDTH-1:0]        mag_p0;
  logic                         vld_p0;
  logic                         in_win_p0;

  assign err_p0    = error_i;
  assign mag_p0    = sat_abs(err_p0);
  assign vld_p0    = sample_i;
  assign in_win_p0 = (mag_p0 <= THRESH_V);

  // Stage p1: registered state, counters and outputs
  state_t              state_p1, state_nxt;
  logic [HIT_W-1:0]    hit_p1, hit_nxt;
  logic [HOLD_W-1:0]   hold_p1, hold_nxt;
  logic [MISS_W-1:0]   miss_p1, miss_nxt;
  logic [KP_WIDTH-1:0] kp_p1, kp_nxt;
  logic [KI_WIDTH-1:0] ki_p1, ki_nxt;
  logic                loop_en_p1, lock_p1, lost_p1, lost_nxt;

  always_comb begin
    state_nxt = state_p1;
    hit_nxt   = hit_p1;
    hold_nxt  = hold_p1;
    miss_nxt  = miss_p1;
    kp_nxt    = kp_p1;
    ki_nxt    = ki_p1;
    lost_nxt  = 1'b0;
    if (!enable_i) begin
      // Dropping the run request wins over any sample-driven transition.
      state_nxt = S_IDLE;
      hit_nxt   = '0;
      hold_nxt  = '0;
      miss_nxt  = '0;
      kp_nxt    = kp_acq_i;
      ki_nxt    = ki_acq_i;
    end else begin
      unique case (state_p1)
        S_IDLE: begin
          state_nxt = S_ACQ;
          kp_nxt    = kp_acq_i;
          ki_nxt    = ki_acq_i;
        end
        S_ACQ: begin
          kp_nxt = kp_acq_i;
          ki_nxt = ki_acq_i;
          if (vld_p0) begin
            if (!in_win_p0) begin
              hit_nxt = '0;
            end else if ((hit_p1 + 1'b1) == LOCK_V) begin
              state_nxt = S_SHIFT;
              hit_nxt   = '0;
`ifndef ADPLL_GAIN_RAMP_EN
              kp_nxt    = kp_trk_i;
              ki_nxt    = ki_trk_i;
`endif
            end else begin
              hit_nxt = hit_p1 + 1'b1;
            end
          end
        end
        S_SHIFT: begin
`ifdef ADPLL_GAIN_RAMP_EN
          if (vld_p0) begin
            kp_nxt   = step_kp(kp_p1, kp_trk_i);
            ki_nxt   = step_ki(ki_p1, ki_trk_i);
            hold_nxt = (hold_p1 == HOLD_V) ? hold_p1 : hold_p1 + 1'b1;
            if (kp_nxt == kp_trk_i && ki_nxt == ki_trk_i && hold_nxt >= HOLD_V) begin
              state_nxt = S_TRACK;
              hold_nxt  = '0;
            end
          end
`else
          kp_nxt = kp_trk_i;
          ki_nxt = ki_trk_i;
          if (vld_p0) begin
            if ((hold_p1 + 1'b1) == HOLD_V) begin
              state_nxt = S_TRACK;
              hold_nxt  = '0;
            end else begin
              hold_nxt = hold_p1 + 1'b1;
            end
          end
`endif
        end
        S_TRACK: begin
          kp_nxt = kp_trk_i;
          ki_nxt = ki_trk_i;
          if (vld_p0) begin
            if (in_win_p0) begin
              miss_nxt = '0;
            end else if ((miss_p1 + 1'b1) == UNLOCK_V) begin
              state_nxt = S_ACQ;
              miss_nxt  = '0;
              hit_nxt   = '0;
              hold_nxt  = '0;
              lost_nxt  = 1'b1;
              kp_nxt    = kp_acq_i;
              ki_nxt    = ki_acq_i;
            end else begin
              miss_nxt = miss_p1 + 1'b1;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      state_p1   <= S_IDLE;
      hit_p1     <= '0;
      hold_p1    <= '0;
      miss_p1    <= '0;
      kp_p1      <= '0;
      ki_p1      <= '0;
      loop_en_p1 <= 1'b0;
      lock_p1    <= 1'b0;
      lost_p1    <= 1'b0;
    end else begin
      state_p1   <= state_nxt;
      hit_p1     <= hit_nxt;
      hold_p1    <= hold_nxt;
      miss_p1    <= miss_nxt;
      kp_p1      <= kp_nxt;
      ki_p1      <= ki_nxt;
      loop_en_p1 <= (state_nxt != S_IDLE);
      lock_p1    <= (state_nxt == S_TRACK);
      lost_p1    <= lost_nxt;
    end
  end

  assign kp_o        = kp_p1;
  assign ki_o        = ki_p1;
  assign loop_en_o   = loop_en_p1;
  assign lock_o      = lock_p1;
  assign lost_lock_o = lost_p1;
  assign state_o     = state_p1;

endmodule

// File: doc/adpll_gain_scheduler.md
Name: adpll_gain_scheduler

Overview:
Gear-shift and lock controller for one NetworkRing ADPLL node.
- Drives the node's enable and kp/ki gain inputs.
- Starts each lock attempt with wide "acquire" gains. Once the node's signed phase error stays inside a window long enough, switches to narrow "track" gains and asserts lock.
- Drops back to acquisition on sustained loss of lock.
- Sits between the top-level switch/config logic and each ADPLL instance, all on the 258 MHz fabric clock.

Parameters:
PDET_WIDTH, 5, width of signed two's-complement phase error input
KP_WIDTH, 5, kp gain width (unsigned)
KI_WIDTH, 7, ki gain width (unsigned)
LOCK_THRESH, 2, max |error| (inclusive) counted as in-window
LOCK_COUNT, 1024, consecutive in-window samples required to leave ACQUIRE
SHIFT_HOLD, 16, samples ignored after gear shift before entering TRACK
UNLOCK_COUNT, 8, consecutive out-of-window samples in TRACK that declare loss of lock

Ports:
fpga_clk_i  in  1  fabric clock (258 MHz)
reset_i  in  1  synchronous reset, active-high
enable_i  in  1  run request; low forces IDLE
sample_i  in  1  one-cycle strobe: error_i valid this cycle (one per reference period)
error_i  in  PDET_WIDTH  signed phase error from the ADPLL detector
kp_acq_i  in  KP_WIDTH  acquire-phase kp
ki_acq_i  in  KI_WIDTH  acquire-phase ki
kp_trk_i  in  KP_WIDTH  track-phase kp
ki_trk_i  in  KI_WIDTH  track-phase ki
kp_o  out  KP_WIDTH  gain to ADPLL kp_i
ki_o  out  KI_WIDTH  gain to ADPLL ki_i
loop_en_o  out  1  to ADPLL enable_i
lock_o  out  1  high only in TRACK
lost_lock_o  out  1  one-cycle pulse on TRACK->ACQUIRE
state_o  out  2  00 IDLE, 01 ACQUIRE, 10 SHIFT, 11 TRACK

Behaviour:
Clock and reset:
- Single clock fpga_clk_i; reset_i is synchronous and active-high.
- Reset: state IDLE; kp_o=0, ki_o=0, loop_en_o=0, lock_o=0, lost_lock_o=0; all counters 0.

Error magnitude and window:
- |error_i| is computed in PDET_WIDTH bits. The most negative code (-2^(PDET_WIDTH-1)) saturates to 2^(PDET_WIDTH-1)-1.
- In-window means |error_i| <= LOCK_THRESH.
- error_i is ignored when sample_i is low.

Timing:
- All outputs are registered.
- A decision made on the sample_i cycle n is visible on the outputs at n+1.

States:
- IDLE: loop_en_o=0; kp_o/ki_o track the acq inputs (registered). enable_i=1 -> ACQUIRE.
- ACQUIRE: loop_en_o=1; kp_o/ki_o = acq inputs.
  - In-window sample: hit counter +1.
  - Out-of-window sample: hit counter cleared.
  - Sample that makes hit count = LOCK_COUNT -> SHIFT; counter cleared.
- SHIFT: kp_o/ki_o = trk inputs from the first SHIFT cycle. Error is ignored. Every sample_i increments the hold counter; the sample that reaches SHIFT_HOLD -> TRACK.
- TRACK: lock_o=1; gains = trk inputs.
  - Out-of-window sample: miss counter +1.
  - In-window sample: miss counter cleared.
  - Miss count reaching UNLOCK_COUNT -> ACQUIRE: lock_o=0, lost_lock_o pulses for 1 cycle, all counters cleared, acq gains restored.

Boundary conditions:
- enable_i low in any state -> IDLE next cycle. This has priority over a simultaneous sample_i transition; no lost_lock_o pulse, counters cleared.
- Gain inputs may change at any time; the selected set propagates with 1-cycle latency.
- Counters are sized clog2(param+1) and never wrap.
- reset_i mid-operation returns to the reset values above on the next edge, regardless of state.

Optional Feature:
ADPLL_GAIN_RAMP_EN
- Defined: on entry to SHIFT, kp_o/ki_o start at their acq values. On each sample_i, each gain steps one LSB toward its trk value; a gain that has reached its trk value holds. SHIFT exits to TRACK on the first sample at which both gains equal trk and the hold count >= SHIFT_HOLD. The hold counter runs in parallel with the ramp.
- Undefined: gains step directly to trk on SHIFT entry, as in Behaviour.

Test Plan:
Bench parameters: LOCK_COUNT=8, LOCK_THRESH=2, SHIFT_HOLD=4, UNLOCK_COUNT=3; acq gains kp=8/ki=16; trk gains kp=2/ki=1.
1. Reset, then enable_i=0 for 5 cycles -> state_o=00, loop_en_o=0, kp_o=8, ki_o=16, lock_o=0.
2. enable_i=1, then 8 samples with error=+1 -> state_o=10 the cycle after the 8th sample, kp_o=2, ki_o=1. After 4 more samples (error=+15, ignored) -> state_o=11, lock_o=1.
3. In ACQUIRE: 7 samples error=-2, then 1 sample error=+3 -> still ACQUIRE. A further 8 in-window samples are needed for SHIFT. Also, error=-16 (5-bit) counts as out-of-window.
4. In TRACK: misses, misses, hit, then 3 misses -> lock_o falls and lost_lock_o pulses exactly once, 1 cycle after the third consecutive miss; state_o=01, kp_o=8.
5. enable_i dropped on the same cycle as the 8th qualifying sample in ACQUIRE -> next state IDLE (not SHIFT), loop_en_o=0, no lock_o/lost_lock_o.
6. With ADPLL_GAIN_RAMP_EN defined, SHIFT from kp 8->2 and ki 16->1 -> kp_o steps 7,6,...,2 and ki_o steps 15,...,1 on successive samples. TRACK is entered on the 15th SHIFT sample.
